// File: rtl/upscaler_pkg.sv
// rtl/upscaler_pkg.sv - shared types and width helpers for the upscaler stream front-end
package upscaler_pkg;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  function automatic int ph_width(input int scale);
    return (scale <= 2) ? 1 : $clog2(scale);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit scale_ok(input int scale);
    return (scale >= 1) && (scale <= 4);
  endfunction

endpackage

// File: rtl/upscale_row_store.sv
// rtl/upscale_row_store.sv - one source row of pixels, sync write, async read
module upscale_row_store #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upscale_stream_expander.sv
// rtl/upscale_stream_expander.sv - expands source pixels into a SCALExSCALE phase-tagged sample stream
module upscale_stream_expander
  import upscaler_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 72,
  parameter int SCALE  = 3,
  parameter int DATA_W = 8,
  localparam int PH_W  = ph_width(SCALE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_pixel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PH_W-1:0]   m_h_phase,
  output logic [PH_W-1:0]   m_v_phase,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy
);

  localparam int CW = idx_width(IMG_W);
  localparam int RW = idx_width(IMG_H);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SCALE - 1);

  if (!scale_ok(SCALE)) begin : g_scale_check
    $error("upscale_stream_expander: SCALE must be in 1..4");
  end

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [PH_W-1:0]   h_cnt;
  logic [PH_W-1:0]   v_cnt;
  logic [DATA_W-1:0] buf_rdata;
  logic              load_en, take, advance;
  logic              h_last, c_last, v_last, r_last;
  logic [DATA_W-1:0] next_pixel;

  assign load_en = !m_valid || m_ready;
  assign s_ready = !rst && (state == ST_FILL) && load_en && (h_cnt == '0);
  assign take    = s_valid && s_ready;
  assign h_last  = (h_cnt == PH_LAST);
  assign c_last  = (col == COL_LAST);
  assign v_last  = (v_cnt == PH_LAST);
  assign r_last  = (row == ROW_LAST);

  // In FILL the output register still holds the current pixel while its h-repeats go out.
  always_comb begin
    advance    = 1'b0;
    next_pixel = m_pixel;
    if (state == ST_REPLAY) begin
      advance    = load_en;
      next_pixel = buf_rdata;
    end else if (h_cnt == '0) begin
      advance    = take;
      next_pixel = s_pixel;
    end else begin
      advance    = load_en;
    end
  end

  upscale_row_store #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_row_store (
    .clk   (clk),
    .we    (take),
    .waddr (col),
    .wdata (s_pixel),
    .raddr (col),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FILL;
      col       <= '0;
      row       <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      m_pixel   <= '0;
      m_valid   <= 1'b0;
      m_h_phase <= '0;
      m_v_phase <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      m_eof     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load_en) begin
        m_valid <= advance;
        if (advance) begin
          m_pixel   <= next_pixel;
          m_h_phase <= h_cnt;
          m_v_phase <= v_cnt;
          m_sof     <= (row == '0) && (v_cnt == '0) && (col == '0) && (h_cnt == '0);
          m_eol     <= c_last && h_last;
          m_eof     <= c_last && h_last && r_last && v_last;
          if (!h_last) begin
            h_cnt <= h_cnt + 1'b1;
          end else begin
            h_cnt <= '0;
            if (!c_last) begin
              col <= col + 1'b1;
            end else begin
              col <= '0;
              if (v_last) begin
                v_cnt <= '0;
                state <= ST_FILL;
                row   <= r_last ? '0 : row + 1'b1;
              end else begin
                v_cnt <= v_cnt + 1'b1;
                state <= ST_REPLAY;
              end
            end
          end
        end
      end
      // A pixel accepted on the eof handshake cycle keeps busy high across frames.
      if (take) busy <= 1'b1;
      else if (m_valid && m_ready && m_eof) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upscale_stream_expander.sv
// tb/tb_upscale_stream_expander.sv - randomized self-checking bench for upscale_stream_expander
module tb_upscale_stream_expander;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_pixel = '0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic       sel_b = 1'b0;

  logic       sa_ready, ma_valid, ma_sof, ma_eol, ma_eof, busy_a;
  logic [7:0] ma_pixel;
  logic [1:0] ma_h, ma_v;
  logic       sb_ready, mb_valid, mb_sof, mb_eol, mb_eof, busy_b;
  logic [7:0] mb_pixel;
  logic [0:0] mb_h, mb_v;

  logic       o_ready, o_valid, o_sof, o_eol, o_eof, o_busy;
  logic [7:0] o_pixel;
  logic [1:0] o_h, o_v;

  always #5 clk = ~clk;

  upscale_stream_expander #(.IMG_W(W), .IMG_H(H), .SCALE(3), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(sa_ready),
    .m_pixel(ma_pixel), .m_valid(ma_valid), .m_ready(m_ready), .m_h_phase(ma_h),
    .m_v_phase(ma_v), .m_sof(ma_sof), .m_eol(ma_eol), .m_eof(ma_eof), .busy(busy_a)
  );

  upscale_stream_expander #(.IMG_W(W), .IMG_H(H), .SCALE(1), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(sb_ready),
    .m_pixel(mb_pixel), .m_valid(mb_valid), .m_ready(m_ready), .m_h_phase(mb_h),
    .m_v_phase(mb_v), .m_sof(mb_sof), .m_eol(mb_eol), .m_eof(mb_eof), .busy(busy_b)
  );

  always_comb begin
    if (sel_b) begin
      o_ready = sb_ready; o_valid = mb_valid; o_pixel = mb_pixel;
      o_h = {1'b0, mb_h}; o_v = {1'b0, mb_v};
      o_sof = mb_sof; o_eol = mb_eol; o_eof = mb_eof; o_busy = busy_b;
    end else begin
      o_ready = sa_ready; o_valid = ma_valid; o_pixel = ma_pixel;
      o_h = ma_h; o_v = ma_v;
      o_sof = ma_sof; o_eol = ma_eol; o_eof = ma_eof; o_busy = busy_a;
    end
  end

  logic [7:0]  in_px[$];
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  int stall_viol, sready_viol, busy_low, bubbles;
  int cur_s = 3;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // Reference: every source pixel expands to an s x s block, rows replayed s times.
  task automatic build_model(input int s, input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < H; r++)
        for (int v = 0; v < s; v++)
          for (int c = 0; c < W; c++)
            for (int h = 0; h < s; h++) begin
              bit sof, eol, eof;
              sof = (r == 0) && (v == 0) && (c == 0) && (h == 0);
              eol = (c == W - 1) && (h == s - 1);
              eof = eol && (r == H - 1) && (v == s - 1);
              exp_q.push_back({in_px[f*W*H + r*W + c], 2'(h), 2'(v), sof, eol, eof});
            end
  endtask

  task automatic fill_pixels(input int n, input bit ramp);
    in_px.delete();
    for (int i = 0; i < n; i++) in_px.push_back(ramp ? 8'(8'h10 + i) : 8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives pixels and records output handshakes; no judgement made here.
  task automatic run_stream(input int n_samples, input bit rand_ready, input bit rand_valid,
                            input int gap_len);
    int idx = 0, hs = 0, budget = 0, gap_left = 0, nl, p, frame;
    bit gap_done = 0, started = 0, prev_stall = 0;
    logic [14:0] cur, prev_v;
    got_q.delete(); got_cyc.delete(); acc_cyc.delete();
    stall_viol = 0; sready_viol = 0; busy_low = 0; bubbles = 0;
    frame = W * H * cur_s * cur_s;
    prev_v = '0;
    while (hs < n_samples && budget < 5000) begin
      @(negedge clk);
      budget++; cyc++;
      m_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (gap_len > 0 && !gap_done && idx == 2) begin gap_left = gap_len; gap_done = 1; end
      s_valid = (idx < in_px.size()) && (gap_left == 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      s_pixel = (idx < in_px.size()) ? in_px[idx] : 8'h00;
      if (gap_left > 0) gap_left--;
      #1;
      cur = {o_pixel, o_h, o_v, o_sof, o_eol, o_eof};
      if (prev_stall && (!o_valid || cur !== prev_v)) stall_viol++;
      nl = hs + (o_valid ? 1 : 0);
      p = nl % frame;
      if (o_ready && !(((p / (W * cur_s)) % cur_s == 0) && (p % cur_s == 0))) sready_viol++;
      if (started && !o_busy) busy_low++;
      if (o_valid && m_ready) begin got_q.push_back(cur); got_cyc.push_back(cyc); hs++; end
      else if (!o_valid && started) bubbles++;
      if (s_valid && o_ready) begin acc_cyc.push_back(cyc); idx++; started = 1; end
      prev_stall = o_valid && !m_ready;
      prev_v = cur;
    end
    @(negedge clk);
    cyc++;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({o_ready, o_valid, o_pixel, o_h, o_v, o_sof, o_eol, o_eof, o_busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h required 0",
               {o_ready, o_valid, o_pixel, o_h, o_v, o_sof, o_eol, o_eof, o_busy});
    end
    do_reset();
    @(negedge clk); #1;
    tests++;
    if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_sready_after got %b required 1", o_ready); end
  endtask

  task automatic test_basic();
    cur_s = 3; do_reset();
    fill_pixels(W * H, 1); build_model(3, 1);
    run_stream(exp_q.size(), 0, 0, 0);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL basic_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
    tests++;
    if (acc_cyc.size() < 1 || got_cyc.size() < 1 || got_cyc[0] != acc_cyc[0] + 1) begin
      fails++; $display("FAIL basic_latency first accept/sample cycles not one apart");
    end
    tests++;
    if (bubbles != 0) begin fails++; $display("FAIL basic_throughput bubbles got %0d required 0", bubbles); end
    tests++;
    if (sready_viol != 0) begin fails++; $display("FAIL basic_sready got %0d required 0", sready_viol); end
  endtask

  task automatic test_stall();
    cur_s = 3; do_reset();
    fill_pixels(W * H, 0); build_model(3, 1);
    run_stream(exp_q.size(), 1, 1, 0);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL stall_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
    tests++;
    if (stall_viol != 0) begin fails++; $display("FAIL stall_hold changes got %0d required 0", stall_viol); end
    tests++;
    if (sready_viol != 0) begin fails++; $display("FAIL stall_sready got %0d required 0", sready_viol); end
  endtask

  task automatic test_gap();
    cur_s = 3; do_reset();
    fill_pixels(W * H, 1); build_model(3, 1);
    run_stream(exp_q.size(), 0, 0, 5);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL gap_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL gap_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
    tests++;
    if (bubbles == 0) begin fails++; $display("FAIL gap_bubble got 0 idle cycles required >0"); end
    tests++;
    if (sready_viol != 0) begin fails++; $display("FAIL gap_sready got %0d required 0", sready_viol); end
  endtask

  task automatic test_reset_mid();
    cur_s = 3; do_reset();
    fill_pixels(W * H, 0);
    run_stream(16, 0, 0, 0);
    rst = 1'b1;
    #1;
    tests++;
    if ({o_ready, o_valid, o_pixel, o_h, o_v, o_sof, o_eol, o_eof, o_busy} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got %h required 0",
               {o_ready, o_valid, o_pixel, o_h, o_v, o_sof, o_eol, o_eof, o_busy});
    end
    @(negedge clk); rst = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
        fails++; $display("FAIL midreset_idle busy %b valid %b required 0 0", o_busy, o_valid);
      end
    end
    fill_pixels(W * H, 0); build_model(3, 1);
    run_stream(exp_q.size(), 1, 0, 0);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL midreset_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL midreset_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    cur_s = 3; do_reset();
    fill_pixels(2 * W * H, 0); build_model(3, 2);
    run_stream(exp_q.size(), 0, 0, 0);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL b2b_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
    tests++;
    if (got_cyc.size() < 73 || got_cyc[72] != got_cyc[71] + 1) begin
      fails++; $display("FAIL b2b_gap second sof not on the cycle after eof");
    end
    tests++;
    if (busy_low != 0) begin fails++; $display("FAIL b2b_busy low cycles got %0d required 0", busy_low); end
  endtask

  task automatic test_scale1();
    sel_b = 1'b1; cur_s = 1; do_reset();
    fill_pixels(W * H, 0); build_model(1, 1);
    run_stream(exp_q.size(), 1, 1, 0);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL s1_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [14:0] g;
      g = (i < got_q.size()) ? got_q[i] : 15'hx;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL s1_sample %0d got %h required %h", i, g, exp_q[i]); end
    end
    tests++;
    if (stall_viol != 0) begin fails++; $display("FAIL s1_hold changes got %0d required 0", stall_viol); end
    sel_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_scale1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
